// File: rtl/id_scoreboard_if.sv
// Decode/writeback hazard-tracking bundle between the pipeline and id_scoreboard.
// The master drives ID/WB/flush status; the slave (scoreboard) returns the stall and debug outputs.
interface id_scoreboard_if #(
    parameter int TOT_W = 6
);
    logic             ds_valid;
    logic [4:0]       ds_rs1;
    logic             ds_rs1_en;
    logic [4:0]       ds_rs2;
    logic             ds_rs2_en;
    logic [4:0]       ds_dest;
    logic             ds_rf_we;
    logic             ds_issue;
    logic             wb_valid;
    logic             wb_rf_we;
    logic [4:0]       wb_dest;
    logic             flush;
    logic             ds_stall;
    logic [TOT_W-1:0] inflight;
    logic             sb_err;

    modport master (
        output ds_valid, ds_rs1, ds_rs1_en, ds_rs2, ds_rs2_en, ds_dest, ds_rf_we, ds_issue,
        output wb_valid, wb_rf_we, wb_dest, flush,
        input  ds_stall, inflight, sb_err
    );

    modport slave (
        input  ds_valid, ds_rs1, ds_rs1_en, ds_rs2, ds_rs2_en, ds_dest, ds_rf_we, ds_issue,
        input  wb_valid, wb_rf_we, wb_dest, flush,
        output ds_stall, inflight, sb_err
    );
endinterface

// File: rtl/id_scoreboard.sv
// GPR write scoreboard: per-register pending-write counters that drive the decode-stage stall.
// Optional macro SB_WB_BYPASS_EN: a source retiring in WB this cycle no longer stalls ID.
module id_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 6
) (
    input logic           clk,
    input logic           resetn,
    id_scoreboard_if.slave sb
);

`ifdef SB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [TOT_W-1:0] inflight_q;
    logic             sb_err_q;

    logic inc, dec, same_reg, inc_ok, dec_ok, err_set;
    logic ret_rs1, ret_rs2, ret_dest;
    logic hit1, hit2, full, stall;

    // Saturating helpers: counters never wrap in either direction.
    function automatic logic [CNT_W-1:0] cnt_sat_dec(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '0) ? c - 1'b1 : c;
    endfunction

    function automatic logic [TOT_W-1:0] tot_step(input logic [TOT_W-1:0] t,
                                                  input logic up, input logic down);
        logic [TOT_W-1:0] r;
        r = t;
        if (up && !down && t != TOT_MAX)
            r = t + 1'b1;
        else if (down && !up && t != '0)
            r = t - 1'b1;
        return r;
    endfunction

    always_comb begin
        inc      = sb.ds_issue & sb.ds_rf_we & (sb.ds_dest != 5'd0);
        dec      = sb.wb_valid & sb.wb_rf_we & (sb.wb_dest != 5'd0);
        same_reg = inc & dec & (sb.ds_dest == sb.wb_dest);
        inc_ok   = inc & ~same_reg & (cnt[sb.ds_dest] != CNT_MAX);
        dec_ok   = dec & ~same_reg & (cnt[sb.wb_dest] != '0);

        // Retiring-this-cycle qualifiers only matter when WB write-through bypass is built in.
        ret_rs1  = BYPASS & dec & (sb.wb_dest == sb.ds_rs1);
        ret_rs2  = BYPASS & dec & (sb.wb_dest == sb.ds_rs2);
        ret_dest = BYPASS & dec & (sb.wb_dest == sb.ds_dest);

        hit1  = sb.ds_rs1_en & (sb.ds_rs1 != 5'd0) & (cnt_sat_dec(cnt[sb.ds_rs1], ret_rs1) != '0);
        hit2  = sb.ds_rs2_en & (sb.ds_rs2 != 5'd0) & (cnt_sat_dec(cnt[sb.ds_rs2], ret_rs2) != '0);
        full  = sb.ds_rf_we & (sb.ds_dest != 5'd0) &
                (cnt_sat_dec(cnt[sb.ds_dest], ret_dest) == CNT_MAX);
        stall = sb.ds_valid & (hit1 | hit2 | full);

        // Counter misuse is ignored on a flush cycle since the flush discards the state anyway.
        err_set = (sb.ds_issue & stall) |
                  (~sb.flush & inc & ~same_reg & (cnt[sb.ds_dest] == CNT_MAX)) |
                  (~sb.flush & dec & ~same_reg & (cnt[sb.wb_dest] == '0));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            inflight_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            if (err_set)
                sb_err_q <= 1'b1;
            if (sb.flush) begin
                for (int r = 0; r < NREG; r++)
                    cnt[r] <= '0;
                inflight_q <= '0;
            end else begin
                // inc_ok and dec_ok never target the same register, so both updates can land.
                if (inc_ok)
                    cnt[sb.ds_dest] <= cnt[sb.ds_dest] + 1'b1;
                if (dec_ok)
                    cnt[sb.wb_dest] <= cnt[sb.wb_dest] - 1'b1;
                inflight_q <= tot_step(inflight_q, inc_ok, dec_ok);
            end
        end
    end

    assign sb.ds_stall = stall;
    assign sb.inflight = inflight_q;
    assign sb.sb_err   = sb_err_q;

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
Register-hazard scoreboard that sequences the decode stage. It tracks in-flight GPR writes issued from ID toward EX/MEM/WB and drives the stall that gates ds_ready_go. A per-register counter is incremented on ID issue and decremented on WB retire. The ID stage stalls while any source register, or a saturated destination, is pending. Replaces the hard-wired ds_ready_go = 1 in the decode stage.

Parameters:
NREG, 32, number of architectural GPRs tracked (r0 never tracked)
CNT_W, 2, per-register in-flight counter width; max pending writes per register = 2^CNT_W-1
TOT_W, 6, width of the total in-flight write counter

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
ds_valid  in  1  ID holds a valid instruction
ds_rs1  in  5  source 1 register number (rk)
ds_rs1_en  in  1  source 1 is read
ds_rs2  in  5  source 2 register number (rj)
ds_rs2_en  in  1  source 2 is read
ds_dest  in  5  destination register
ds_rf_we  in  1  instruction writes the GPR file
ds_issue  in  1  ID->EX handshake fired this cycle (ds_to_es_valid & es_allowin)
wb_valid  in  1  WB stage holds a valid instruction
wb_rf_we  in  1  WB instruction writes the GPR file
wb_dest  in  5  WB destination register
flush  in  1  pipeline flush (exception/ertn); discards all in-flight writes
ds_stall  out  1  ID must hold; ds_ready_go = ~ds_stall
inflight  out  TOT_W  total pending GPR writes (debug/perf)
sb_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (resetn low, asynchronous): all cnt[r]=0, inflight=0, sb_err=0. ds_stall is therefore 0 at reset.
- inc = ds_issue & ds_rf_we & (ds_dest!=0). dec = wb_valid & wb_rf_we & (wb_dest!=0).
- Counter update at posedge clk:
  - cnt[ds_dest] += inc.
  - cnt[wb_dest] -= dec.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inflight += inc - dec, with the same rule.
- flush has priority over inc/dec in the same cycle: all cnt and inflight clear to 0 on the next edge. sb_err is not cleared by flush.
- hit1 = ds_rs1_en & (ds_rs1!=0) & (cnt[ds_rs1]!=0). hit2 is the same for rs2.
- full = ds_rf_we & (ds_dest!=0) & (cnt[ds_dest]==2^CNT_W-1).
- ds_stall = ds_valid & (hit1 | hit2 | full). Combinational from registered counters plus current ID inputs, so it has zero-cycle latency.
- Writes to r0 are never tracked, and reads of r0 never stall.
- Without bypass, a source whose counter is retiring in the current cycle still stalls this cycle; the stall releases the next cycle.
- Protocol errors set sb_err, which stays 1 until reset. Each error case and its handling:
  - ds_issue while ds_stall=1: the increment is still applied.
  - dec on a counter already 0: the counter holds at 0.
  - inc on a counter at max: the counter saturates.
  - Counter overflow/underflow never wraps.
- Reset asserted mid-operation: all state clears immediately, regardless of clock.

Optional Feature:
SB_WB_BYPASS_EN.
- Defined: hit1/hit2 use an effective count, cnt[r] - (dec & wb_dest==r). A source retiring this cycle does not stall, because the regfile write-through supplies the value. full uses the same effective count.
- Undefined: raw counters are used, costing one extra stall cycle on WB-adjacent dependencies.

Test Plan:
1. Reset release, ds_valid=1, rs1=5 en, no prior issue -> ds_stall=0, inflight=0, sb_err=0.
2. Issue dest=r5 with rf_we, next cycle ID reads rs1=r5 -> ds_stall=1. wb_valid/wb_dest=5 one cycle later -> stall drops the cycle after retire (same cycle with SB_WB_BYPASS_EN), and cnt[5] returns to 0.
3. Three back-to-back issues to dest=r7 (CNT_W=2), then fourth ID instr with dest=r7 and no sources -> ds_stall=1 (full), inflight=3. One WB retire of r7 -> stall clears.
4. Same-cycle ds_issue dest=r9 and WB retire r9 with cnt[9]=1 -> cnt[9] stays 1, inflight unchanged.
5. inflight=4, flush=1 together with ds_issue dest=r3 -> next cycle all counters 0, inflight=0, r3 not pending.
6. WB retire r12 with cnt[12]=0 -> sb_err=1 and cnt[12]=0. Subsequent flush leaves sb_err=1. resetn low asynchronously -> sb_err=0 before the next clock edge.
